// File: rtl/q_update_sched_pkg.sv
// Shared constants and FSM encoding for the q_update scheduler and its helpers.
package q_update_sched_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int STATE_WIDTH  = 8;
  localparam int ACTION_WIDTH = 2;
  localparam int ACTION_NUM   = 2 ** ACTION_WIDTH;
  localparam int ADDR_WIDTH   = STATE_WIDTH + ACTION_WIDTH;

  localparam logic [DATA_WIDTH-1:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_Q,
    ST_RD_NXT,
    ST_RD_LAST,
    ST_ISSUE,
    ST_WAIT_QU,
    ST_WRITE
  } sched_state_t;

endpackage

// File: rtl/q_update_sched_fp_greater.sv
// Combinational a > b for IEEE-754 single precision; +0 and -0 compare equal.
module fp_greater
  import q_update_sched_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  gt
);

  logic                  sign_a;
  logic                  sign_b;
  logic [DATA_WIDTH-2:0] mag_a;
  logic [DATA_WIDTH-2:0] mag_b;

  assign sign_a = a[DATA_WIDTH-1];
  assign sign_b = b[DATA_WIDTH-1];
  assign mag_a  = a[DATA_WIDTH-2:0];
  assign mag_b  = b[DATA_WIDTH-2:0];

  always_comb begin
    gt = 1'b0;
    if (mag_a == '0 && mag_b == '0) begin
      gt = 1'b0;
    end else if (sign_a != sign_b) begin
      gt = sign_b;
    end else if (!sign_a) begin
      gt = (mag_a > mag_b);
    end else begin
      gt = (mag_a < mag_b);
    end
  end

endmodule

// File: rtl/q_update_sched.sv
// Sequences one transition through Q-table reads, max search, one q_update op and write-back.
module q_update_sched
  import q_update_sched_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [STATE_WIDTH-1:0]  i_state,
  input  logic [ACTION_WIDTH-1:0] i_action,
  input  logic [DATA_WIDTH-1:0]   i_reward,
  input  logic [STATE_WIDTH-1:0]  i_next_state,
  input  logic                    i_terminal,
  output logic                    o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   o_mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]   i_mem_rd_data,
  output logic                    o_mem_wr_en,
  output logic [ADDR_WIDTH-1:0]   o_mem_wr_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wr_data,
  output logic                    o_qu_valid,
  output logic [DATA_WIDTH-1:0]   o_qu_q,
  output logic [DATA_WIDTH-1:0]   o_qu_max_q,
  output logic [DATA_WIDTH-1:0]   o_qu_rt,
  input  logic                    i_qu_valid,
  input  logic [DATA_WIDTH-1:0]   i_qu_q_new,
  output logic                    o_done,
  output logic [ACTION_WIDTH-1:0] o_best_action,
  output logic                    o_error
);

  localparam logic [ACTION_WIDTH-1:0] LAST_IDX = ACTION_WIDTH'(ACTION_NUM - 1);

  sched_state_t            state_reg;
  sched_state_t            state_next;
  logic [STATE_WIDTH-1:0]  s_reg;
  logic [STATE_WIDTH-1:0]  ns_reg;
  logic [ACTION_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0]   r_reg;
  logic                    term_reg;
  logic [ACTION_WIDTH-1:0] idx_reg;
  logic [ACTION_WIDTH-1:0] idx_next;
  logic                    tag_vld_reg;
  logic                    tag_is_q_reg;
  logic [ACTION_WIDTH-1:0] tag_idx_reg;
  logic [DATA_WIDTH-1:0]   q_reg;
  logic [DATA_WIDTH-1:0]   max_reg;
  logic [ACTION_WIDTH-1:0] best_reg;
  logic [DATA_WIDTH-1:0]   q_new_reg;
  logic [ACTION_WIDTH-1:0] best_out_reg;
  logic                    error_reg;
  logic                    transfer;
  logic                    cand_gt;

  assign transfer = i_valid && (state_reg == ST_IDLE);

  fp_greater u_cmp (
    .a  (i_mem_rd_data),
    .b  (max_reg),
    .gt (cand_gt)
  );

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    o_ready       = 1'b0;
    o_mem_rd_en   = 1'b0;
    o_mem_rd_addr = '0;
    o_mem_wr_en   = 1'b0;
    o_mem_wr_addr = '0;
    o_mem_wr_data = '0;
    o_qu_valid    = 1'b0;
    o_done        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_next = ST_RD_Q;
      end
      ST_RD_Q: begin
        o_mem_rd_en   = 1'b1;
        o_mem_rd_addr = {s_reg, a_reg};
        idx_next      = '0;
        state_next    = term_reg ? ST_RD_LAST : ST_RD_NXT;
      end
      ST_RD_NXT: begin
        o_mem_rd_en   = 1'b1;
        o_mem_rd_addr = {ns_reg, idx_reg};
        idx_next      = idx_reg + 1'b1;
        if (idx_reg == LAST_IDX) state_next = ST_RD_LAST;
      end
      ST_RD_LAST: state_next = ST_ISSUE;
      ST_ISSUE: begin
        o_qu_valid = 1'b1;
        state_next = ST_WAIT_QU;
      end
      ST_WAIT_QU: begin
        if (i_qu_valid) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        o_mem_wr_en   = 1'b1;
        o_mem_wr_addr = {s_reg, a_reg};
        o_mem_wr_data = q_new_reg;
        o_done        = 1'b1;
        state_next    = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      s_reg        <= '0;
      ns_reg       <= '0;
      a_reg        <= '0;
      r_reg        <= '0;
      term_reg     <= 1'b0;
      idx_reg      <= '0;
      tag_vld_reg  <= 1'b0;
      tag_is_q_reg <= 1'b0;
      tag_idx_reg  <= '0;
      q_reg        <= '0;
      max_reg      <= '0;
      best_reg     <= '0;
      q_new_reg    <= '0;
      best_out_reg <= '0;
      error_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;

      if (transfer) begin
        s_reg    <= i_state;
        a_reg    <= i_action;
        r_reg    <= i_reward;
        ns_reg   <= i_next_state;
        term_reg <= i_terminal;
        // Terminal transitions never overwrite these, leaving max = +0.0, best = 0.
        max_reg  <= FP_ZERO;
        best_reg <= '0;
      end

      // Tag travels one cycle behind the read strobe, matching RAM read latency.
      tag_vld_reg  <= o_mem_rd_en;
      tag_is_q_reg <= (state_reg == ST_RD_Q);
      tag_idx_reg  <= idx_reg;

      if (tag_vld_reg) begin
        if (tag_is_q_reg) begin
          q_reg <= i_mem_rd_data;
        end else if (tag_idx_reg == '0 || cand_gt) begin
          max_reg  <= i_mem_rd_data;
          best_reg <= tag_idx_reg;
        end
      end

      if (state_reg == ST_WAIT_QU && i_qu_valid) begin
        q_new_reg    <= i_qu_q_new;
        best_out_reg <= best_reg;
      end

      if (i_qu_valid && state_reg != ST_WAIT_QU) error_reg <= 1'b1;
    end
  end

  assign o_qu_q        = q_reg;
  assign o_qu_max_q    = max_reg;
  assign o_qu_rt       = r_reg;
  assign o_best_action = best_out_reg;
  assign o_error       = error_reg;

endmodule
